nttd_lane_router: RTL and testbench
===================================

// Module: nttd_lane_router
// PURPOSE
//  Registered, parametrised lane router for the radix-16 NTT datapath, sitting between butterfly stages.
//  Accepts one N_LANE-wide beat per handshake and routes it through a per-frame permutation:
//  pass-through, bit-reverse, rotate or XOR-swizzle.
//  Adds valid/ready flow control, a frame beat counter and a last-beat flag, with one output register stage.
// PARAMETERS
//  P_WIDTH    64    bits per lane
//  N_LANE     16    lane count; power of 2, >=2
//  LOG_LANE   4     log2(N_LANE)
//  FRAME_LEN  1024  beats per frame; >=1
//  CNT_W      10    beat counter width; 2**CNT_W >= FRAME_LEN
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  in_valid   in   1                 input beat valid
//  in_ready   out  1                 router can accept a beat
//  data_in    in   N_LANE*P_WIDTH    lane i = data_in[i*P_WIDTH +: P_WIDTH]
//  cfg_mode   in   2                 0 pass, 1 bit-reverse, 2 rotate, 3 xor; sampled at frame start
//  cfg_amt    in   LOG_LANE          rotate / xor amount; sampled at frame start
//  out_valid  out  1                 output beat valid
//  out_ready  in   1                 downstream accepts the beat
//  data_out   out  N_LANE*P_WIDTH    routed beat, same lane packing
//  out_last   out  1                 qualifies the last beat of a frame
//  busy       out  1                 a frame is in progress (beat_cnt != 0)
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, data_out=0, out_last=0, beat_cnt=0, mode_q=0, amt_q=0, busy=0.
//  Handshakes:
//   - in_ready = !out_valid || out_ready (combinational). Input accepted when in_valid && in_ready.
//   - Output transfers when out_valid && out_ready.
//  Latency: 1 cycle. The beat accepted at edge k appears on data_out after edge k, with out_valid=1.
//  Back-pressure: out_valid && !out_ready holds data_out/out_last stable; in_ready=0. No beat is dropped or duplicated.
//  Throughput: 1 beat/cycle when out_ready=1; a simultaneous output transfer and input accept reloads the register.
//  Empty: acceptance cycle with no new input and out_ready=1 -> out_valid falls to 0 the next cycle.
//  Config:
//   - On an accepted beat with beat_cnt==0, cfg_mode/cfg_amt are used for that beat and latched into mode_q/amt_q.
//   - Later beats of the frame use mode_q/amt_q. cfg changes mid-frame are ignored.
//  Routing, for output lane o in 0..N_LANE-1 (indices mod N_LANE, LOG_LANE-bit unsigned):
//   - mode 0: out[o] = in[o]
//   - mode 1: out[o] = in[bitrev(o)]
//   - mode 2: out[o] = in[(o+amt) mod N_LANE]
//   - mode 3: out[o] = in[o ^ amt]
//   Lane data is never modified, only moved.
//  Beat counter: increments on each accepted beat. On the beat where beat_cnt==FRAME_LEN-1 it wraps to 0,
//   and out_last is registered as 1 with that beat. FRAME_LEN==1 makes every beat last and re-samples cfg every beat.
//  busy = (beat_cnt != 0).
//  Reset mid-frame: counter, config and output register clear at once; the next accepted beat starts a new frame.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, data_out=0, busy=0, in_ready=1.
//    Release rst_n; first accepted beat latches cfg.
//  2 Pass/latency: mode0, lane i = i, one beat -> next cycle out_valid=1 and lane i = i. in_valid low -> out_valid drops after the output transfer.
//  3 Permutations (N_LANE=16, lane i = 16'hA000+i):
//     mode1 -> lane1 = A008
//     mode2 amt=3 -> lane0 = A003, lane15 = A002
//     mode3 amt=5 -> lane0 = A005
//  4 Back-pressure: stream 8 beats with out_ready toggled 1,0,0,1 repeating -> all 8 beats out in order, none lost.
//    Whenever out_valid=1 and out_ready=0, in_ready=0 and data_out is stable.
//  5 Frame/config (FRAME_LEN=4): frame A with mode2 amt=1, cfg switched to mode1 after beat 0 -> beats 1-3 still rotated by 1.
//    out_last=1 only on beat 3. Beat 4 uses mode1.
//  6 Mid-frame reset: pulse rst_n low after beat 2 of 4 -> busy=0, out_valid=0. The next beat is treated as beat 0 and samples fresh cfg.

Source files
------------

// File: rtl/nttd_lane_router_if.sv
// Lane router stream bundle: input beat handshake + frame config, output beat handshake + status.
// Latency: none (wiring only).
// Backpressure: carries the in_ready/out_ready pair; the router side is the slave modport.
//
// Ports (signals):
//   in_valid/in_ready/data_in   input beat handshake, lane i = data_in[i*P_WIDTH +: P_WIDTH]
//   cfg_mode/cfg_amt            permutation select and rotate/xor amount, used at frame start
//   out_valid/out_ready/data_out/out_last  routed beat handshake, out_last marks the frame's final beat
//   busy                        a frame is partially transferred
interface nttd_lane_router_if #(
  parameter int P_WIDTH  = 64,
  parameter int N_LANE   = 16,
  parameter int LOG_LANE = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_LANE*P_WIDTH-1:0]  data_in;
  logic [1:0]                 cfg_mode;
  logic [LOG_LANE-1:0]        cfg_amt;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_LANE*P_WIDTH-1:0]  data_out;
  logic                       out_last;
  logic                       busy;

  // Router side.
  modport slave (
    input  in_valid,
    input  data_in,
    input  cfg_mode,
    input  cfg_amt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output out_last,
    output busy
  );

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid,
    output data_in,
    output cfg_mode,
    output cfg_amt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/nttd_lane_router.sv
// Per-frame lane permutation (pass / bit-reverse / rotate / xor) between NTT butterfly stages.
// Latency: 1 cycle, one output register stage, 1 beat/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output beat is held stable.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus_if  stream bundle (slave modport): input beat + cfg, output beat + last flag, busy status
module nttd_lane_router #(
  parameter int P_WIDTH   = 64,
  parameter int N_LANE    = 16,
  parameter int LOG_LANE  = 4,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  nttd_lane_router_if.slave  bus_if
);

  localparam int                 BUS_W    = N_LANE * P_WIDTH;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_LEN - 1);

  // Frame configuration captured on the first beat of each frame.
  typedef struct packed {
    logic [1:0]          mode;
    logic [LOG_LANE-1:0] amt;
  } cfg_t;

  // Registered state.
  logic               out_valid_q, out_valid_d;
  logic [BUS_W-1:0]   data_q,      data_d;
  logic               last_q,      last_d;
  logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
  cfg_t               cfg_q,       cfg_d;

  // Combinational helpers.
  logic               in_ready;
  logic               accept;
  logic               frame_start;
  logic               frame_end;
  cfg_t               cfg_use;
  logic [BUS_W-1:0]   routed;

  // Source lane feeding output lane o under the given mode/amount.
  // All arithmetic is LOG_LANE bits wide so rotate wraps mod N_LANE for free.
  function automatic logic [LOG_LANE-1:0] src_lane(
    input logic [LOG_LANE-1:0] o,
    input logic [1:0]          mode,
    input logic [LOG_LANE-1:0] amt
  );
    logic [LOG_LANE-1:0] rev;
    rev = '0;
    for (int b = 0; b < LOG_LANE; b++) begin
      rev[b] = o[LOG_LANE-1-b];
    end
    case (mode)
      2'd0:    src_lane = o;
      2'd1:    src_lane = rev;
      2'd2:    src_lane = o + amt;
      default: src_lane = o ^ amt;
    endcase
  endfunction

  // The output register can take a new beat when empty or when its beat leaves this cycle.
  assign in_ready    = !out_valid_q || bus_if.out_ready;
  assign accept      = bus_if.in_valid && in_ready;
  assign frame_start = (beat_cnt_q == '0);
  assign frame_end   = (beat_cnt_q == LAST_CNT);

  // The first beat of a frame routes with the live cfg inputs; later beats use the latched copy,
  // so cfg edits mid-frame cannot tear a frame.
  always_comb begin
    cfg_use = cfg_q;
    if (frame_start) begin
      cfg_use.mode = bus_if.cfg_mode;
      cfg_use.amt  = bus_if.cfg_amt;
    end
  end

  // Pure lane crossbar: each output lane copies exactly one input lane unmodified.
  always_comb begin
    int src;
    routed = '0;
    src    = 0;
    for (int o = 0; o < N_LANE; o++) begin
      src = int'(src_lane(LOG_LANE'(o), cfg_use.mode, cfg_use.amt));
      routed[o*P_WIDTH +: P_WIDTH] = bus_if.data_in[src*P_WIDTH +: P_WIDTH];
    end
  end

  // Next-state logic.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    cfg_d       = cfg_q;

    if (accept) begin
      // Load (or reload, when the held beat leaves in the same cycle).
      out_valid_d = 1'b1;
      data_d      = routed;
      last_d      = frame_end;
      beat_cnt_d  = frame_end ? '0 : beat_cnt_q + CNT_W'(1);
      if (frame_start) begin
        cfg_d = cfg_use;
      end
    end else if (bus_if.out_ready) begin
      // Held beat drained with nothing behind it: register empties.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      beat_cnt_q  <= '0;
      cfg_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
      cfg_q       <= cfg_d;
    end
  end

  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.data_out  = data_q;
  assign bus_if.out_last  = last_q;
  assign bus_if.busy      = (beat_cnt_q != '0);

endmodule

// File: tb/tb_nttd_lane_router.sv
// Directed bench for nttd_lane_router with 16-bit lanes and a 4-beat frame.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1-2 ns after it.
// Backpressure: out_ready driven from a fixed 1,0,0,1 pattern in the stall scenario.
module tb_nttd_lane_router;

  localparam int P  = 16;
  localparam int N  = 16;
  localparam int L  = 4;
  localparam int FL = 4;
  localparam int CW = 2;
  localparam int W  = N * P;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nttd_lane_router_if #(.P_WIDTH(P), .N_LANE(N), .LOG_LANE(L)) bus ();

  nttd_lane_router #(
    .P_WIDTH(P), .N_LANE(N), .LOG_LANE(L), .FRAME_LEN(FL), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  // Beat whose lane i carries base+i.
  function automatic logic [W-1:0] mk_beat(input logic [P-1:0] base);
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[i*P +: P] = base + P'(i);
    return b;
  endfunction

  function automatic logic [P-1:0] lane(input logic [W-1:0] d, input int i);
    return d[i*P +: P];
  endfunction

  task automatic pulse_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One accepted beat with out_ready high; returns 1 ns after the capturing edge.
  task automatic send_beat(input logic [W-1:0] d, input logic [1:0] m, input logic [L-1:0] a);
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.cfg_mode  = m;
    bus.cfg_amt   = a;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = mk_beat(16'h5500);
    bus.cfg_mode  = 2'd0;
    bus.cfg_amt   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h want 0", bus.data_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    pulse_reset();
    send_beat(mk_beat(16'h0000), 2'd0, 4'd0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.data_out !== mk_beat(16'h0000)) begin errors++; $display("FAIL pass_data got %h want %h", bus.data_out, mk_beat(16'h0000)); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pass_busy got %b want 1", bus.busy); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL pass_last got %b want 0", bus.out_last); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_permutations();
    // Bit-reverse: out[1]=in[8], out[3]=in[12].
    pulse_reset();
    send_beat(mk_beat(16'hA000), 2'd1, 4'd0);
    checks++; if (lane(bus.data_out, 1) !== 16'hA008) begin errors++; $display("FAIL bitrev_l1 got %h want A008", lane(bus.data_out, 1)); end
    checks++; if (lane(bus.data_out, 3) !== 16'hA00C) begin errors++; $display("FAIL bitrev_l3 got %h want A00C", lane(bus.data_out, 3)); end
    // Rotate by 3: out[0]=in[3], out[15]=in[2].
    pulse_reset();
    send_beat(mk_beat(16'hA000), 2'd2, 4'd3);
    checks++; if (lane(bus.data_out, 0) !== 16'hA003) begin errors++; $display("FAIL rot_l0 got %h want A003", lane(bus.data_out, 0)); end
    checks++; if (lane(bus.data_out, 15) !== 16'hA002) begin errors++; $display("FAIL rot_l15 got %h want A002", lane(bus.data_out, 15)); end
    // XOR 5: out[0]=in[5], out[7]=in[2].
    pulse_reset();
    send_beat(mk_beat(16'hA000), 2'd3, 4'd5);
    checks++; if (lane(bus.data_out, 0) !== 16'hA005) begin errors++; $display("FAIL xor_l0 got %h want A005", lane(bus.data_out, 0)); end
    checks++; if (lane(bus.data_out, 7) !== 16'hA002) begin errors++; $display("FAIL xor_l7 got %h want A002", lane(bus.data_out, 7)); end
  endtask

  task automatic test_backpressure();
    int           rdy_pat [4] = '{1, 0, 0, 1};
    int           sent  = 0;
    int           rcvd  = 0;
    logic         stall = 1'b0;
    logic [W-1:0] held  = '0;
    logic         held_last = 1'b0;
    logic [W-1:0] exp_d;
    pulse_reset();
    bus.cfg_mode = 2'd0;
    bus.cfg_amt  = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      bus.out_ready = rdy_pat[c % 4] != 0;
      bus.in_valid  = (sent < 8);
      bus.data_in   = mk_beat(16'h1000 + P'(sent * 16));
      #1;
      if (stall) begin
        checks++;
        if (bus.data_out !== held || bus.out_last !== held_last) begin
          errors++; $display("FAIL bp_hold got %h/%b want %h/%b", bus.data_out, bus.out_last, held, held_last);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        stall = 1'b1; held = bus.data_out; held_last = bus.out_last;
      end else begin
        stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_d = mk_beat(16'h1000 + P'(rcvd * 16));
        checks++;
        if (bus.data_out !== exp_d || bus.out_last !== (rcvd % 4 == 3)) begin
          errors++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", rcvd, bus.data_out, bus.out_last, exp_d, (rcvd % 4 == 3));
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (rcvd != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rcvd); end
  endtask

  task automatic test_frame_cfg();
    logic [P-1:0] base;
    pulse_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      base = 16'hB000 + P'(k * 16);
      bus.in_valid = 1'b1;
      bus.data_in  = mk_beat(base);
      if (k == 0) begin bus.cfg_mode = 2'd2; bus.cfg_amt = 4'd1; end
      else        begin bus.cfg_mode = 2'd1; bus.cfg_amt = 4'd0; end
      @(posedge clk); #1;
      if (k < 4) begin
        checks++;
        if (lane(bus.data_out, 0) !== base + 16'd1 || lane(bus.data_out, 15) !== base) begin
          errors++; $display("FAIL frame_rot_beat%0d got l0=%h l15=%h want %h %h", k, lane(bus.data_out, 0), lane(bus.data_out, 15), base + 16'd1, base);
        end
        checks++;
        if (bus.out_last !== (k == 3)) begin errors++; $display("FAIL frame_last_beat%0d got %b want %b", k, bus.out_last, (k == 3)); end
      end else begin
        checks++;
        if (lane(bus.data_out, 1) !== base + 16'd8 || lane(bus.data_out, 0) !== base) begin
          errors++; $display("FAIL frame_newcfg got l1=%h l0=%h want %h %h", lane(bus.data_out, 1), lane(bus.data_out, 0), base + 16'd8, base);
        end
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL frame_newcfg_last got %b want 0", bus.out_last); end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    for (int k = 0; k < 3; k++) send_beat(mk_beat(16'hC000 + P'(k * 16)), 2'd3, 4'd1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(mk_beat(16'hD000), 2'd2, 4'd4);
    checks++; if (lane(bus.data_out, 0) !== 16'hD004) begin errors++; $display("FAIL mid_freshcfg got %h want D004", lane(bus.data_out, 0)); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL mid_last got %b want 0", bus.out_last); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_after got %b want 1", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_permutations();
    test_backpressure();
    test_frame_cfg();
    test_mid_reset();
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
